// File: rtl/pcap_ts_pkg.sv
// Shared definitions for the pcap timestamp tagger: FSM encoding, default
// meta signature and a width-parametrised byte reverse.
package pcap_ts_pkg;

    localparam logic [1:0] S_HEAD = 2'd0;
    localparam logic [1:0] S_META = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [63:0] DEFAULT_SIGNATURE = 64'h00000000_efbeadde;

    // Reverses the byte order of the low nbytes of v (1..8); upper bytes return 0.
    function automatic logic [63:0] byte_rev(input logic [63:0] v, input int nbytes);
        logic [63:0] r;
        for (int i = 0; i < 8; i++)
            r[8*i +: 8] = v[8*(7-i) +: 8];
        return r >> (64 - 8*nbytes);
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI4-Stream register slice: registered outputs, registered ready,
// one cycle of latency and full throughput. Resets to empty.
module axis_skid_reg #(
    parameter int DATA_WIDTH  = 512,
    parameter int TUSER_WIDTH = 128
) (
    input  logic                      axis_aclk,
    input  logic                      axis_aresetn,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic [TUSER_WIDTH-1:0]    s_tuser,
    input  logic                      s_tlast,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic [TUSER_WIDTH-1:0]    m_tuser,
    output logic                      m_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready
);

    localparam int W = DATA_WIDTH + DATA_WIDTH/8 + TUSER_WIDTH + 1;

    logic [W-1:0] in_bus;
    logic [W-1:0] out_bus_p1;
    logic [W-1:0] skid_bus_p1;
    logic         vld_p1;
    logic         skid_vld_p1;

    assign in_bus = {s_tlast, s_tuser, s_tkeep, s_tdata};

    // Output register loads whenever it is empty or draining; a beat arriving
    // while the output is stalled parks in the skid entry.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            out_bus_p1  <= '0;
            skid_bus_p1 <= '0;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (m_tready || !vld_p1) begin
            if (skid_vld_p1) begin
                out_bus_p1  <= skid_bus_p1;
                vld_p1      <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else if (s_tvalid) begin
                out_bus_p1 <= in_bus;
                vld_p1     <= 1'b1;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (s_tvalid && !skid_vld_p1) begin
            skid_bus_p1 <= in_bus;
            skid_vld_p1 <= 1'b1;
        end
    end

    assign s_tready = !skid_vld_p1;
    assign m_tvalid = vld_p1;
    assign {m_tlast, m_tuser, m_tkeep, m_tdata} = out_bus_p1;

endmodule

// File: rtl/pcap_ts_tagger.sv
// Drops timestamp meta packets and stamps their timestamp into the tuser of the
// following data packet(s). Optional event counters under `PCAP_TS_STATS_EN.
module pcap_ts_tagger
    import pcap_ts_pkg::*;
#(
    parameter int          DATA_WIDTH     = 512,
    parameter int          TUSER_WIDTH    = 128,
    parameter logic [63:0] SIGNATURE      = DEFAULT_SIGNATURE,
    parameter int          TS_WIDTH       = 32,
    parameter int          TS_BYTE_OFFSET = 12,
    parameter int          TS_TUSER_LSB   = 32,
    parameter int          TS_MODE        = 0
) (
    input  logic                      axis_aclk,
    input  logic                      axis_aresetn,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [31:0]               stat_meta_cnt,
    output logic [31:0]               stat_tagged_cnt,
    output logic [31:0]               stat_overwrite_cnt
);

    logic [1:0]             state;
    logic                   ts_pend;
    logic [TS_WIDTH-1:0]    ts;
    logic                   pkt_pend;
    logic [TS_WIDTH-1:0]    pkt_ts;
    logic                   in_head;
    logic                   meta_head;
    logic                   fwd_valid;
    logic                   fwd_fire;
    logic                   meta_fire;
    logic                   skid_ready;
    logic                   cur_pend;
    logic [TS_WIDTH-1:0]    cur_ts;
    logic [TS_WIDTH-1:0]    ts_new;
    logic [63:0]            ts_raw;
    logic [TUSER_WIDTH-1:0] fwd_tuser;

    assign in_head       = (state == S_HEAD);
    assign meta_head     = in_head && (s_axis_tdata[63:0] == SIGNATURE);
    assign s_axis_tready = axis_aresetn && ((state == S_META) || meta_head || skid_ready);
    assign fwd_valid     = s_axis_tvalid && !meta_head && (state != S_META);
    assign fwd_fire      = fwd_valid && skid_ready;
    assign meta_fire     = s_axis_tvalid && s_axis_tready && meta_head;

    // The head beat sees the live pending flag; later beats reuse its snapshot.
    assign cur_pend = in_head ? ts_pend : pkt_pend;
    assign cur_ts   = in_head ? ts : pkt_ts;

    always_comb begin
        ts_raw = '0;
        ts_raw[TS_WIDTH-1:0] = s_axis_tdata[8*TS_BYTE_OFFSET +: TS_WIDTH];
        ts_new = TS_WIDTH'(byte_rev(ts_raw, TS_WIDTH/8));
        fwd_tuser = s_axis_tuser;
        fwd_tuser[TS_TUSER_LSB +: TS_WIDTH] = cur_pend ? cur_ts : '0;
        fwd_tuser[TS_TUSER_LSB + TS_WIDTH]  = cur_pend;
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state    <= S_HEAD;
            ts_pend  <= 1'b0;
            ts       <= '0;
            pkt_pend <= 1'b0;
            pkt_ts   <= '0;
        end else begin
            if (meta_fire) begin
                ts      <= ts_new;
                ts_pend <= 1'b1;
            end else if (TS_MODE == 0 && fwd_fire && s_axis_tlast && cur_pend) begin
                ts_pend <= 1'b0;
            end
            case (state)
                S_HEAD: begin
                    if (meta_fire) begin
                        state <= s_axis_tlast ? S_HEAD : S_META;
                    end else if (fwd_fire) begin
                        state    <= s_axis_tlast ? S_HEAD : S_DATA;
                        pkt_pend <= ts_pend;
                        pkt_ts   <= ts;
                    end
                end
                S_META:  if (s_axis_tvalid && s_axis_tlast) state <= S_HEAD;
                S_DATA:  if (fwd_fire && s_axis_tlast) state <= S_HEAD;
                default: state <= S_HEAD;
            endcase
        end
    end

    axis_skid_reg #(
        .DATA_WIDTH  (DATA_WIDTH),
        .TUSER_WIDTH (TUSER_WIDTH)
    ) u_skid (
        .axis_aclk    (axis_aclk),
        .axis_aresetn (axis_aresetn),
        .s_tdata      (s_axis_tdata),
        .s_tkeep      (s_axis_tkeep),
        .s_tuser      (fwd_tuser),
        .s_tlast      (s_axis_tlast),
        .s_tvalid     (fwd_valid),
        .s_tready     (skid_ready),
        .m_tdata      (m_axis_tdata),
        .m_tkeep      (m_axis_tkeep),
        .m_tuser      (m_axis_tuser),
        .m_tlast      (m_axis_tlast),
        .m_tvalid     (m_axis_tvalid),
        .m_tready     (m_axis_tready)
    );

`ifdef PCAP_TS_STATS_EN
    logic [31:0] meta_cnt;
    logic [31:0] tagged_cnt;
    logic [31:0] ovw_cnt;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            meta_cnt   <= '0;
            tagged_cnt <= '0;
            ovw_cnt    <= '0;
        end else begin
            if (meta_fire)
                meta_cnt <= meta_cnt + 32'd1;
            if (meta_fire && ts_pend && TS_MODE == 0)
                ovw_cnt <= ovw_cnt + 32'd1;
            if (fwd_fire && in_head && ts_pend)
                tagged_cnt <= tagged_cnt + 32'd1;
        end
    end

    assign stat_meta_cnt      = meta_cnt;
    assign stat_tagged_cnt    = tagged_cnt;
    assign stat_overwrite_cnt = ovw_cnt;
`else
    assign stat_meta_cnt      = '0;
    assign stat_tagged_cnt    = '0;
    assign stat_overwrite_cnt = '0;
`endif

endmodule

// File: tb/tb_pcap_ts_tagger.sv
// Bench for pcap_ts_tagger: one-shot and sticky instances share one input
// stream; each output is scored against its own expected-beat queue.
`timescale 1ns/1ps
module tb_pcap_ts_tagger;

    localparam int DW = 512;
    localparam int KW = DW/8;
    localparam int UW = 128;
    localparam logic [63:0] SIG = 64'h00000000_efbeadde;

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic          axis_aclk    = 1'b0;
    logic          axis_aresetn = 1'b1;
    logic [DW-1:0] s_tdata  = '0;
    logic [KW-1:0] s_tkeep  = '0;
    logic [UW-1:0] s_tuser  = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast  = 1'b0;
    logic          m_tready = 1'b1;

    logic [DW-1:0] m0_tdata, m1_tdata;
    logic [KW-1:0] m0_tkeep, m1_tkeep;
    logic [UW-1:0] m0_tuser, m1_tuser;
    logic          m0_tvalid, m1_tvalid, m0_tlast, m1_tlast;
    logic          s0_tready, s1_tready;
    logic [31:0]   st0_meta, st0_tag, st0_ovw, st1_meta, st1_tag, st1_ovw;

    always #5 axis_aclk = ~axis_aclk;

    pcap_ts_tagger #(.TS_MODE(0)) u_dut_oneshot (
        .axis_aclk (axis_aclk), .axis_aresetn (axis_aresetn),
        .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tuser (s_tuser),
        .s_axis_tvalid (s_tvalid), .s_axis_tlast (s_tlast), .s_axis_tready (s0_tready),
        .m_axis_tdata (m0_tdata), .m_axis_tkeep (m0_tkeep), .m_axis_tuser (m0_tuser),
        .m_axis_tvalid (m0_tvalid), .m_axis_tlast (m0_tlast), .m_axis_tready (m_tready),
        .stat_meta_cnt (st0_meta), .stat_tagged_cnt (st0_tag), .stat_overwrite_cnt (st0_ovw)
    );

    pcap_ts_tagger #(.TS_MODE(1)) u_dut_sticky (
        .axis_aclk (axis_aclk), .axis_aresetn (axis_aresetn),
        .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tuser (s_tuser),
        .s_axis_tvalid (s_tvalid), .s_axis_tlast (s_tlast), .s_axis_tready (s1_tready),
        .m_axis_tdata (m1_tdata), .m_axis_tkeep (m1_tkeep), .m_axis_tuser (m1_tuser),
        .m_axis_tvalid (m1_tvalid), .m_axis_tlast (m1_tlast), .m_axis_tready (m_tready),
        .stat_meta_cnt (st1_meta), .stat_tagged_cnt (st1_tag), .stat_overwrite_cnt (st1_ovw)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected-stream model
    bit          pend0 = 0, pend1 = 0;
    logic [31:0] ts0 = '0, ts1 = '0;
    int          meta_cnt = 0, tagged0 = 0, tagged1 = 0, ovw0 = 0;
    beat_t       q0[$];
    beat_t       q1[$];
    bit          mon_en    = 0;
    bit          rnd_ready = 0;

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [UW-1:0] rand_user();
        logic [UW-1:0] r;
        for (int i = 0; i < UW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic send_beat(input beat_t b);
        int waited;
        waited = 0;
        s_tdata = b.data; s_tkeep = b.keep; s_tuser = b.user; s_tlast = b.last;
        s_tvalid = 1'b1;
        @(negedge axis_aclk);
        while (!s0_tready) begin
            waited++;
            if (waited > 200) begin
                $display("FAIL s_tready_timeout got=0 exp=1");
                $fatal(1, "input stalled");
            end
            @(negedge axis_aclk);
        end
        @(posedge axis_aclk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_meta(input logic [31:0] ts, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = rand_data();
            b.keep = '1;
            b.user = rand_user();
            b.last = (i == nbeats - 1);
            if (i == 0) begin
                b.data[63:0]   = SIG;
                b.data[96 +: 32] = bswap32(ts);
            end
            send_beat(b);
        end
        meta_cnt++;
        if (pend0) ovw0++;
        pend0 = 1; ts0 = ts;
        pend1 = 1; ts1 = ts;
    endtask

    // sig_beat >= 1 places the signature in that non-head beat
    task automatic send_data(input int nbeats, input int sig_beat);
        beat_t b, e;
        bit    tag0, tag1;
        tag0 = pend0;
        tag1 = pend1;
        for (int i = 0; i < nbeats; i++) begin
            b.data = rand_data();
            if (i == 0 && b.data[63:0] == SIG) b.data[0] = ~b.data[0];
            if (i != 0 && i == sig_beat) b.data[63:0] = SIG;
            b.last = (i == nbeats - 1);
            b.keep = b.last ? {$urandom, $urandom} : '1;
            b.user = rand_user();
            e = b;
            e.user[63:32] = tag0 ? ts0 : 32'h0;
            e.user[64]    = tag0;
            q0.push_back(e);
            e.user[63:32] = tag1 ? ts1 : 32'h0;
            e.user[64]    = tag1;
            q1.push_back(e);
            send_beat(b);
        end
        if (tag0) tagged0++;
        if (tag1) tagged1++;
        pend0 = 0;
    endtask

    bit    hold_flag[2];
    beat_t hold_snap[2];

    task automatic mon_dut(input int idx, input beat_t got, input logic vld);
        beat_t e;
        int    n;
        if (hold_flag[idx]) begin
            check($sformatf("hold_vld%0d", idx), DW'(vld), DW'(1));
            check($sformatf("hold_data%0d", idx), got.data, hold_snap[idx].data);
            check($sformatf("hold_user%0d", idx), DW'(got.user), DW'(hold_snap[idx].user));
        end
        hold_flag[idx] = vld && !m_tready;
        hold_snap[idx] = got;
        if (vld && m_tready) begin
            n = (idx == 0) ? q0.size() : q1.size();
            check($sformatf("beat_avail%0d", idx), DW'(n > 0), DW'(1));
            if (n > 0) begin
                if (idx == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                check($sformatf("tdata%0d", idx), got.data, e.data);
                check($sformatf("tkeep%0d", idx), DW'(got.keep), DW'(e.keep));
                check($sformatf("tuser%0d", idx), DW'(got.user), DW'(e.user));
                check($sformatf("tlast%0d", idx), DW'(got.last), DW'(e.last));
            end
        end
    endtask

    always @(negedge axis_aclk) begin
        if (mon_en) begin
            mon_dut(0, {m0_tlast, m0_tuser, m0_tkeep, m0_tdata}, m0_tvalid);
            mon_dut(1, {m1_tlast, m1_tuser, m1_tkeep, m1_tdata}, m1_tvalid);
        end else begin
            hold_flag[0] = 0;
            hold_flag[1] = 0;
        end
    end

    initial begin
        forever begin
            @(posedge axis_aclk);
            #1;
            m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while ((q0.size() != 0 || q1.size() != 0) && cyc < 2000) begin
            @(negedge axis_aclk);
            cyc++;
        end
        check({tag, "_drain"}, DW'(q0.size() + q1.size()), DW'(0));
        repeat (2) @(posedge axis_aclk);
        #1;
    endtask

    task automatic check_stats(input string tag);
`ifdef PCAP_TS_STATS_EN
        check({tag, "_meta0"}, DW'(st0_meta), DW'(meta_cnt));
        check({tag, "_tag0"},  DW'(st0_tag),  DW'(tagged0));
        check({tag, "_ovw0"},  DW'(st0_ovw),  DW'(ovw0));
        check({tag, "_meta1"}, DW'(st1_meta), DW'(meta_cnt));
        check({tag, "_tag1"},  DW'(st1_tag),  DW'(tagged1));
        check({tag, "_ovw1"},  DW'(st1_ovw),  DW'(0));
`else
        check({tag, "_meta0"}, DW'(st0_meta), DW'(0));
        check({tag, "_tag0"},  DW'(st0_tag),  DW'(0));
        check({tag, "_ovw0"},  DW'(st0_ovw),  DW'(0));
        check({tag, "_tag1"},  DW'(st1_tag),  DW'(0));
`endif
    endtask

    initial begin
        beat_t b;
        #1 axis_aresetn = 1'b0;
        repeat (3) @(posedge axis_aclk);
        #1;
        check("rst_m_tvalid", DW'(m0_tvalid), DW'(0));
        check("rst_m_tdata", m0_tdata, DW'(0));
        check("rst_m_tuser", DW'(m1_tuser), DW'(0));
        check("rst_s_tready0", DW'(s0_tready), DW'(0));
        check("rst_s_tready1", DW'(s1_tready), DW'(0));
        check("rst_stat_meta", DW'(st0_meta), DW'(0));
        @(negedge axis_aclk);
        axis_aresetn = 1'b1;
        @(posedge axis_aclk);
        #1;
        mon_en = 1;

        // one-shot tag on the next packet only
        send_meta(32'h01020304, 1);
        send_data(3, -1);
        send_data(2, -1);
        drain("t1");
        check_stats("t1");

        // back-to-back meta: newest wins
        send_meta(32'h11111111, 1);
        send_meta(32'h22222222, 1);
        send_data(1, -1);
        drain("t2");
        check_stats("t2");

        // sticky instance tags all following packets
        send_meta(32'hA5A55A5A, 2);
        for (int i = 0; i < 4; i++) send_data(1 + i % 3, -1);
        drain("t3");
        check_stats("t3");

        // signature only honoured on head beats
        send_meta(32'hCAFEF00D, 3);
        send_data(3, 1);
        send_data(2, -1);
        drain("t4");
        check_stats("t4");

        // mixed traffic under random backpressure
        rnd_ready = 1;
        for (int p = 0; p < 100; p++) begin
            if ($urandom_range(0, 3) == 0)
                send_meta($urandom, $urandom_range(1, 3));
            else
                send_data($urandom_range(1, 4), ($urandom_range(0, 3) == 0) ? 1 : -1);
            if ($urandom_range(0, 4) == 0) @(posedge axis_aclk);
            #1;
        end
        drain("t5");
        rnd_ready = 0;
        repeat (2) @(posedge axis_aclk);
        #1;
        check_stats("t5");

        // reset in the middle of a sticky-tagged data packet
        send_meta(32'h5EED5EED, 1);
        drain("t6a");
        mon_en = 0;
        for (int i = 0; i < 2; i++) begin
            b.data = rand_data();
            if (i == 0 && b.data[63:0] == SIG) b.data[0] = ~b.data[0];
            b.keep = '1;
            b.user = rand_user();
            b.last = 1'b0;
            send_beat(b);
        end
        #2 axis_aresetn = 1'b0;
        #1;
        check("mid_rst_m_tvalid0", DW'(m0_tvalid), DW'(0));
        check("mid_rst_m_tvalid1", DW'(m1_tvalid), DW'(0));
        check("mid_rst_m_tdata", m0_tdata, DW'(0));
        check("mid_rst_m_tuser", DW'(m1_tuser), DW'(0));
        check("mid_rst_s_tready", DW'(s0_tready), DW'(0));
        q0.delete(); q1.delete();
        pend0 = 0; pend1 = 0; ts0 = '0; ts1 = '0;
        meta_cnt = 0; tagged0 = 0; tagged1 = 0; ovw0 = 0;
        check_stats("mid_rst");
        repeat (2) @(negedge axis_aclk);
        axis_aresetn = 1'b1;
        @(posedge axis_aclk);
        #1;
        mon_en = 1;
        send_data(2, -1);
        send_meta(32'h0BADF00D, 1);
        send_data(1, -1);
        drain("t6b");
        check_stats("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
